range_share_ctrl: RTL and testbench
===================================

# range_share_ctrl

Session controller and two-way arbiter for the shared range-finder datapath. It grants the single datapath to one of two sample-stream requesters (A, B) at a time, round-robin. It drives the datapath's `go`/`finish`/data pins with the owner's stream and captures the registered range result. It then returns the result to the owner with a done pulse. It handles single-sample sessions, idle timeouts and requester withdrawal.

## Interface
Parameters:
- `WIDTH`, 8: sample and range width.
- `TIMEOUT`, 15: consecutive sample-less RUN cycles before abort; must be ≥1.

Ports:
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; same net resets the datapath.
- `req_a`, `req_b` in 1: requester wants a session; held high for its duration.
- `valid_a`, `valid_b` in 1: sample present this cycle.
- `last_a`, `last_b` in 1: qualifies `valid_x`; final sample of the session.
- `data_a`, `data_b` in WIDTH: sample value.
- `grant_a`, `grant_b` out 1: one-hot-or-zero ownership; owner may present one sample per cycle while granted (no backpressure).
- `rf_data` out WIDTH, `rf_go` out 1, `rf_finish` out 1: to datapath, combinational from state/owner inputs.
- `rf_range` in WIDTH, `rf_error` in 1: datapath registered range and error flag.
- `result` out WIDTH: captured range, registered.
- `err` out 1: registered; session aborted or datapath error.
- `done_a`, `done_b` out 1: one-cycle pulse, `result`/`err` valid that cycle.

## Operation
- States: IDLE, ARM, RUN, FLUSH, CAPTURE. Registers: `owner`, `last_served`, `hold` (last sample, WIDTH), `idle_cnt` ($clog2(TIMEOUT+1) bits), `abort`.
- IDLE: rf pins all 0.
  - Any `req` → grant the requester not equal to `last_served`, or the only requester → ARM.
  - `abort`, `idle_cnt` cleared.
- ARM: `grant_owner`=1; rf pins 0.
  - `valid && !last` → `rf_go`=1, `rf_data`=data, `hold`<=data → RUN.
  - `valid && last` → `rf_go`=1, `rf_data`=data, `hold`<=data → FLUSH.
  - `req_owner`=0 → IDLE, no done, `last_served` unchanged.
- RUN:
  - `valid && !last` → `rf_data`=data, `hold`<=data, `idle_cnt`<=0.
  - `valid && last` → `rf_finish`=1, `rf_data`=data → CAPTURE.
  - No valid → `rf_data`=`hold` (inside [min,max], so the datapath does not update); `idle_cnt`++.
  - Abort when `idle_cnt`==TIMEOUT-1 with no valid, or when `req_owner`=0 (takes priority over valid). Abort drives `rf_finish`=1, `rf_data`=`hold`, sets `abort`<=1 → CAPTURE.
- FLUSH: `rf_finish`=1, `rf_data`=`hold` → CAPTURE; the single-sample range is 0.
- CAPTURE: grant still high; rf pins 0.
  - `result`<=`rf_range`, `err`<=`abort|rf_error`, `done_owner`<=1, `last_served`<=owner.
  - → IDLE.
- Valid/last/data from the non-owner are ignored. `last_x` without `valid_x` is ignored.
- Arithmetic is the datapath's. The controller does not modify values.

## Timing
- Reset (any state, async): state IDLE, `last_served`=B (A wins first tie), all outputs 0, `result`=0, `err`=0. Reset mid-session produces no done.
- Request seen in IDLE cycle n → grant high cycle n+1.
- Last sample presented cycle t → CAPTURE cycle t+1 (`rf_range` updated at the t+1 edge). At cycle t+2: `done`/`result`/`err` valid, grant low, state IDLE. Earliest next grant is cycle t+3.
- Single-sample session: ARM sample cycle t, FLUSH t+1, CAPTURE t+2, done t+3.
- Timeout: the TIMEOUT-th consecutive empty RUN cycle is the abort cycle.
- `done_a`/`done_b` are never both high. Grants are never both high.

## Test plan
- Reset asserted mid-stream → all outputs 0 immediately. After release, A streams 3,8(last) → `done_a`, `result`=5, `err`=0.
- A only: samples 10,50,30, last 20 → done_a exactly 2 cycles after the last sample, `result`=40, `err`=0. `grant_b` stays 0 throughout.
- `req_a`, `req_b` rise in the same cycle after reset → A granted first. A gives 1,2(last) → 1. B is then granted and gives 7,200(last) → `done_b`, `result`=193. Next tie goes to A.
- Single sample: A ARM presents valid+last, 99 → FLUSH drives `rf_finish` with 99; `result`=0, `err`=0.
- TIMEOUT=4: A gives 5,9, then silence → the 4th empty cycle drives `rf_finish` with `rf_data`=9 → `result`=4, `err`=1. A drops `req_a` during RUN → abort the same cycle, `err`=1.
- B valid pulses while A owns the datapath → no effect on `rf_data` or A's result.

Source files
------------

// File: rtl/range_share_ctrl.sv
// range_share_ctrl: round-robin owner of the shared range-finder datapath, streams owner samples and returns the range
module range_share_ctrl #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_a,
    input  logic             req_b,
    input  logic             valid_a,
    input  logic             valid_b,
    input  logic             last_a,
    input  logic             last_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             grant_a,
    output logic             grant_b,
    output logic [WIDTH-1:0] rf_data,
    output logic             rf_go,
    output logic             rf_finish,
    input  logic [WIDTH-1:0] rf_range,
    input  logic             rf_error,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             done_a,
    output logic             done_b
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ARM, RUN, FLUSH, CAPTURE} state_t;

    state_t           r_state;
    logic             r_owner;
    logic             r_last_served;
    logic [WIDTH-1:0] r_hold;
    logic [CW-1:0]    r_idle_cnt;
    logic             r_abort;
    logic             r_grant_a;
    logic             r_grant_b;
    logic             r_done_a;
    logic             r_done_b;
    logic [WIDTH-1:0] r_result;
    logic             r_err;

    // owner is 0 for A, 1 for B; only the owner's stream is ever looked at
    logic             w_req;
    logic             w_valid;
    logic             w_last;
    logic [WIDTH-1:0] w_data;
    logic             w_stop;
    logic             w_pick_b;

    assign w_req    = r_owner ? req_b   : req_a;
    assign w_valid  = r_owner ? valid_b : valid_a;
    assign w_last   = r_owner ? last_b  : last_a;
    assign w_data   = r_owner ? data_b  : data_a;
    assign w_stop   = !w_req || (!w_valid && r_idle_cnt == CW'(TIMEOUT - 1));
    assign w_pick_b = req_b && (!req_a || !r_last_served);

    assign grant_a = r_grant_a;
    assign grant_b = r_grant_b;
    assign done_a  = r_done_a;
    assign done_b  = r_done_b;
    assign result  = r_result;
    assign err     = r_err;

    // datapath pins; idle RUN cycles replay the held sample so min/max stay put
    always_comb begin
        rf_go     = 1'b0;
        rf_finish = 1'b0;
        rf_data   = '0;
        case (r_state)
            ARM: begin
                rf_go   = w_req && w_valid;
                rf_data = (w_req && w_valid) ? w_data : '0;
            end
            RUN: begin
                rf_finish = w_stop || (w_valid && w_last);
                rf_data   = (w_valid && !w_stop) ? w_data : r_hold;
            end
            FLUSH: begin
                rf_finish = 1'b1;
                rf_data   = r_hold;
            end
            default: ;
        endcase
    end

    // session FSM with registered grant/done/result outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_owner       <= 1'b0;
            r_last_served <= 1'b1;
            r_hold        <= '0;
            r_idle_cnt    <= '0;
            r_abort       <= 1'b0;
            r_grant_a     <= 1'b0;
            r_grant_b     <= 1'b0;
            r_done_a      <= 1'b0;
            r_done_b      <= 1'b0;
            r_result      <= '0;
            r_err         <= 1'b0;
        end else begin
            r_done_a <= 1'b0;
            r_done_b <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_abort    <= 1'b0;
                    r_idle_cnt <= '0;
                    if (req_a || req_b) begin
                        r_owner   <= w_pick_b;
                        r_grant_a <= !w_pick_b;
                        r_grant_b <= w_pick_b;
                        r_state   <= ARM;
                    end
                end
                ARM: begin
                    if (!w_req) begin
                        r_grant_a <= 1'b0;
                        r_grant_b <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_valid) begin
                        r_hold  <= w_data;
                        r_state <= w_last ? FLUSH : RUN;
                    end
                end
                RUN: begin
                    if (w_stop) begin
                        r_abort <= 1'b1;
                        r_state <= CAPTURE;
                    end else if (w_valid && w_last) begin
                        r_state <= CAPTURE;
                    end else if (w_valid) begin
                        r_hold     <= w_data;
                        r_idle_cnt <= '0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
                FLUSH: r_state <= CAPTURE;
                CAPTURE: begin
                    r_result      <= rf_range;
                    r_err         <= r_abort | rf_error;
                    r_done_a      <= !r_owner;
                    r_done_b      <= r_owner;
                    r_last_served <= r_owner;
                    r_grant_a     <= 1'b0;
                    r_grant_b     <= 1'b0;
                    r_state       <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_range_share_ctrl.sv
// tb_range_share_ctrl: directed scenarios against a behavioural min/max range datapath
module tb_range_share_ctrl;
    logic       clock = 1'b0;
    logic       reset;
    logic       req_a, req_b, valid_a, valid_b, last_a, last_b;
    logic [7:0] data_a, data_b;
    logic       grant_a, grant_b, rf_go, rf_finish, err, done_a, done_b;
    logic [7:0] rf_data, result, rf_range;
    logic       rf_error;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clock = ~clock;

    range_share_ctrl #(.WIDTH(8), .TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .req_a(req_a), .req_b(req_b), .valid_a(valid_a), .valid_b(valid_b),
        .last_a(last_a), .last_b(last_b), .data_a(data_a), .data_b(data_b),
        .grant_a(grant_a), .grant_b(grant_b),
        .rf_data(rf_data), .rf_go(rf_go), .rf_finish(rf_finish),
        .rf_range(rf_range), .rf_error(rf_error),
        .result(result), .err(err), .done_a(done_a), .done_b(done_b)
    );

    // datapath model: go loads min/max, later cycles widen them, range is registered max-min
    logic [7:0] m_mn, m_mx, w_lo, w_hi;
    logic       m_act;
    assign w_lo = (rf_data < m_mn) ? rf_data : m_mn;
    assign w_hi = (rf_data > m_mx) ? rf_data : m_mx;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mn <= '0; m_mx <= '0; rf_range <= '0; m_act <= 1'b0;
        end else if (rf_go) begin
            m_mn <= rf_data; m_mx <= rf_data; rf_range <= '0; m_act <= 1'b1;
        end else if (m_act) begin
            m_mn <= w_lo; m_mx <= w_hi; rf_range <= w_hi - w_lo;
            if (rf_finish) m_act <= 1'b0;
        end
    end

    // grants and dones must never overlap
    always @(negedge clock) begin
        if (grant_a && grant_b) begin n_fail++; $display("FAIL both_grants high"); end
        if (done_a && done_b) begin n_fail++; $display("FAIL both_dones high"); end
    end

    task automatic cyc();
        @(posedge clock); #1;
    endtask

    task automatic set_a(input logic r, input logic v, input logic l, input logic [7:0] d);
        req_a = r; valid_a = v; last_a = l; data_a = d;
    endtask

    task automatic set_b(input logic r, input logic v, input logic l, input logic [7:0] d);
        req_b = r; valid_b = v; last_b = l; data_b = d;
    endtask

    task automatic test_reset();
        reset = 1'b1; rf_error = 1'b0;
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        #3;
        n_chk++; if ({grant_a, grant_b, done_a, done_b, err, rf_go, rf_finish} !== 7'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0", {grant_a, grant_b, done_a, done_b, err, rf_go, rf_finish}); end
        n_chk++; if (result !== 8'd0 || rf_data !== 8'd0) begin n_fail++; $display("FAIL reset_data result %0d rf_data %0d exp 0", result, rf_data); end
        cyc(); reset = 1'b0;
        cyc();
    endtask

    task automatic test_tie();
        set_a(1, 0, 0, 0); set_b(1, 0, 0, 0);
        cyc();
        n_chk++; if ({grant_a, grant_b} !== 2'b10) begin n_fail++; $display("FAIL tie_first got %b exp 10", {grant_a, grant_b}); end
        set_a(1, 1, 0, 1); set_b(1, 0, 0, 0);
        cyc(); set_a(1, 1, 1, 2);
        cyc(); set_a(0, 0, 0, 0);
        cyc();
        n_chk++; if (done_a !== 1'b1 || result !== 8'd1 || err !== 1'b0) begin n_fail++; $display("FAIL tie_a_done done %b result %0d err %b exp 1/1/0", done_a, result, err); end
        n_chk++; if (grant_b !== 1'b0) begin n_fail++; $display("FAIL tie_b_early got %b exp 0", grant_b); end
        cyc();
        n_chk++; if (grant_b !== 1'b1) begin n_fail++; $display("FAIL tie_b_grant got %b exp 1", grant_b); end
        set_b(1, 1, 0, 7);
        cyc(); set_b(1, 1, 1, 200);
        cyc(); set_b(0, 0, 0, 0);
        cyc();
        n_chk++; if (done_b !== 1'b1 || done_a !== 1'b0 || result !== 8'd193) begin n_fail++; $display("FAIL tie_b_done done_b %b done_a %b result %0d exp 1/0/193", done_b, done_a, result); end
        set_a(1, 0, 0, 0); set_b(1, 0, 0, 0);
        cyc();
        n_chk++; if ({grant_a, grant_b} !== 2'b10) begin n_fail++; $display("FAIL tie_second got %b exp 10", {grant_a, grant_b}); end
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0);
        cyc();
        n_chk++; if ({grant_a, grant_b} !== 2'b00) begin n_fail++; $display("FAIL arm_withdraw grant got %b exp 00", {grant_a, grant_b}); end
        cyc();
        n_chk++; if ({done_a, done_b} !== 2'b00) begin n_fail++; $display("FAIL arm_withdraw done got %b exp 00", {done_a, done_b}); end
    endtask

    task automatic test_midreset();
        set_a(1, 0, 0, 0);
        cyc(); set_a(1, 1, 0, 50);
        cyc(); set_a(1, 1, 0, 60);
        #1 reset = 1'b1;
        #1;
        n_chk++; if ({grant_a, grant_b, done_a, done_b, rf_go, rf_finish} !== 6'b0 || rf_data !== 8'd0) begin n_fail++; $display("FAIL midreset got %b rf_data %0d exp 0", {grant_a, grant_b, done_a, done_b, rf_go, rf_finish}, rf_data); end
        set_a(1, 0, 0, 0);
        cyc(); reset = 1'b0;
        n_chk++; if (grant_a !== 1'b0) begin n_fail++; $display("FAIL midreset_release grant_a %b exp 0", grant_a); end
        cyc();
        n_chk++; if (grant_a !== 1'b1) begin n_fail++; $display("FAIL midreset_regrant got %b exp 1", grant_a); end
        set_a(1, 1, 0, 3);
        cyc(); set_a(1, 1, 1, 8);
        cyc(); set_a(0, 0, 0, 0);
        cyc();
        n_chk++; if (done_a !== 1'b1 || result !== 8'd5 || err !== 1'b0) begin n_fail++; $display("FAIL midreset_session done %b result %0d err %b exp 1/5/0", done_a, result, err); end
    endtask

    task automatic test_a_only();
        set_a(1, 0, 0, 0);
        cyc();
        set_a(1, 1, 0, 10); #1;
        n_chk++; if (rf_go !== 1'b1 || rf_data !== 8'd10) begin n_fail++; $display("FAIL a_only_go go %b data %0d exp 1/10", rf_go, rf_data); end
        cyc(); set_a(1, 1, 0, 50);
        cyc(); set_a(1, 1, 0, 30);
        cyc(); set_a(1, 1, 1, 20); #1;
        n_chk++; if (rf_finish !== 1'b1 || rf_data !== 8'd20) begin n_fail++; $display("FAIL a_only_finish fin %b data %0d exp 1/20", rf_finish, rf_data); end
        cyc(); set_a(0, 0, 0, 0); #1;
        n_chk++; if (grant_a !== 1'b1 || done_a !== 1'b0 || rf_finish !== 1'b0) begin n_fail++; $display("FAIL a_only_capture grant %b done %b fin %b exp 1/0/0", grant_a, done_a, rf_finish); end
        cyc();
        n_chk++; if (done_a !== 1'b1 || result !== 8'd40 || err !== 1'b0 || grant_a !== 1'b0 || grant_b !== 1'b0) begin n_fail++; $display("FAIL a_only_done done %b result %0d err %b ga %b gb %b exp 1/40/0/0/0", done_a, result, err, grant_a, grant_b); end
        cyc();
        n_chk++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL a_only_pulse got %b exp 0", done_a); end
    endtask

    task automatic test_single();
        set_a(1, 0, 0, 0);
        cyc(); set_a(1, 1, 1, 99); #1;
        n_chk++; if (rf_go !== 1'b1 || rf_finish !== 1'b0 || rf_data !== 8'd99) begin n_fail++; $display("FAIL single_arm go %b fin %b data %0d exp 1/0/99", rf_go, rf_finish, rf_data); end
        cyc(); set_a(1, 0, 0, 0); #1;
        n_chk++; if (rf_finish !== 1'b1 || rf_go !== 1'b0 || rf_data !== 8'd99) begin n_fail++; $display("FAIL single_flush fin %b go %b data %0d exp 1/0/99", rf_finish, rf_go, rf_data); end
        cyc(); set_a(0, 0, 0, 0);
        cyc();
        n_chk++; if (done_a !== 1'b1 || result !== 8'd0 || err !== 1'b0) begin n_fail++; $display("FAIL single_done done %b result %0d err %b exp 1/0/0", done_a, result, err); end
    endtask

    task automatic test_timeout();
        set_a(1, 0, 0, 0);
        cyc(); set_a(1, 1, 0, 5);
        cyc(); set_a(1, 1, 0, 9);
        cyc(); set_a(1, 0, 0, 0); #1;
        n_chk++; if (rf_finish !== 1'b0 || rf_data !== 8'd9) begin n_fail++; $display("FAIL timeout_empty1 fin %b data %0d exp 0/9", rf_finish, rf_data); end
        cyc();
        cyc(); #1;
        n_chk++; if (rf_finish !== 1'b0) begin n_fail++; $display("FAIL timeout_empty3 fin %b exp 0", rf_finish); end
        cyc(); #1;
        n_chk++; if (rf_finish !== 1'b1 || rf_data !== 8'd9) begin n_fail++; $display("FAIL timeout_abort fin %b data %0d exp 1/9", rf_finish, rf_data); end
        cyc(); set_a(0, 0, 0, 0);
        cyc();
        n_chk++; if (done_a !== 1'b1 || result !== 8'd4 || err !== 1'b1) begin n_fail++; $display("FAIL timeout_done done %b result %0d err %b exp 1/4/1", done_a, result, err); end
    endtask

    task automatic test_withdraw();
        set_a(1, 0, 0, 0);
        cyc(); set_a(1, 1, 0, 10);
        cyc(); set_a(1, 1, 0, 30);
        cyc(); set_a(0, 1, 0, 100); #1;
        n_chk++; if (rf_finish !== 1'b1 || rf_data !== 8'd30) begin n_fail++; $display("FAIL withdraw_abort fin %b data %0d exp 1/30", rf_finish, rf_data); end
        cyc(); set_a(0, 0, 0, 0);
        cyc();
        n_chk++; if (done_a !== 1'b1 || result !== 8'd20 || err !== 1'b1) begin n_fail++; $display("FAIL withdraw_done done %b result %0d err %b exp 1/20/1", done_a, result, err); end
    endtask

    task automatic test_rf_error();
        set_a(1, 0, 0, 0);
        cyc(); set_a(1, 1, 0, 3);
        cyc(); set_a(1, 1, 1, 4);
        cyc(); set_a(0, 0, 0, 0); rf_error = 1'b1;
        cyc(); rf_error = 1'b0;
        n_chk++; if (done_a !== 1'b1 || result !== 8'd1 || err !== 1'b1) begin n_fail++; $display("FAIL rf_error_done done %b result %0d err %b exp 1/1/1", done_a, result, err); end
    endtask

    task automatic test_back_to_back();
        set_a(1, 0, 0, 0);
        cyc(); set_a(1, 1, 0, 40); set_b(0, 1, 1, 255); #1;
        n_chk++; if (rf_data !== 8'd40 || grant_b !== 1'b0) begin n_fail++; $display("FAIL foreign_arm data %0d gb %b exp 40/0", rf_data, grant_b); end
        cyc(); set_a(1, 1, 0, 60); set_b(0, 1, 0, 0); #1;
        n_chk++; if (rf_data !== 8'd60 || rf_finish !== 1'b0) begin n_fail++; $display("FAIL foreign_run data %0d fin %b exp 60/0", rf_data, rf_finish); end
        cyc(); set_a(1, 0, 0, 0); set_b(0, 1, 1, 1); #1;
        n_chk++; if (rf_data !== 8'd60 || rf_finish !== 1'b0) begin n_fail++; $display("FAIL foreign_idle data %0d fin %b exp 60/0", rf_data, rf_finish); end
        cyc(); set_a(1, 1, 1, 50); set_b(0, 0, 0, 0);
        cyc(); set_a(1, 0, 0, 0);
        cyc();
        n_chk++; if (done_a !== 1'b1 || done_b !== 1'b0 || result !== 8'd20 || err !== 1'b0) begin n_fail++; $display("FAIL foreign_done da %b db %b result %0d err %b exp 1/0/20/0", done_a, done_b, result, err); end
        n_chk++; if (grant_a !== 1'b0) begin n_fail++; $display("FAIL b2b_gap grant_a %b exp 0", grant_a); end
        cyc();
        n_chk++; if (grant_a !== 1'b1) begin n_fail++; $display("FAIL b2b_regrant grant_a %b exp 1", grant_a); end
        set_a(0, 0, 0, 0);
        cyc();
        cyc();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_midreset();
        test_a_only();
        test_single();
        test_timeout();
        test_withdraw();
        test_rf_error();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
